mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, byte-addressable, 16-bit-wide memory between two requesters: an instruction fetch port (read-only) and a data port (read/write).
- Sequences each access over a programmable number of cycles, applies round-robin arbitration and rejects unaligned addresses.
- Sits between the fetch/memory pipeline stages and the memory instance. It drives that memory's enable, wr, addr and data_in pins.

Parameters:
- ADDR_WIDTH, 16, byte-address width of all address ports.
- MEM_LAT, 2, cycles the memory port is held per access; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_req  in  1  fetch request; held until i_done.
- i_addr  in  ADDR_WIDTH  fetch byte address.
- i_gnt  out  1  one-cycle pulse: fetch request accepted.
- i_done  out  1  one-cycle pulse: fetch complete; i_rdata/i_err valid.
- i_rdata  out  16  fetched word.
- i_err  out  1  unaligned fetch; valid with i_done.
- d_req  in  1  data request; held until d_done.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  16  write data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  16  read data; 0 for writes.
- d_err  out  1  unaligned data access; valid with d_done.
- mem_enable  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory byte address.
- mem_data_in  out  16  memory write data.
- mem_data_out  in  16  memory read data (combinational).

Behaviour:
- FSM states:
  - IDLE: evaluate requests.
  - ACCESS: hold the memory port for MEM_LAT cycles under a 4-bit down-counter.
  - DONE: one cycle; done pulse to the owner.
- Transitions:
  - IDLE -> ACCESS when a request wins with addr[0]=0.
  - IDLE -> DONE when a request wins with addr[0]=1.
  - ACCESS -> DONE when the counter reaches its final cycle.
  - DONE -> IDLE, unconditionally.
  - Requests seen in DONE are ignored.
- Arbitration:
  - Evaluated in IDLE only; round-robin on a last-owner bit.
  - If both requesters are active, the one that was not last owner wins.
  - Single requester wins immediately.
  - Reset sets last-owner = data, so fetch wins the first tie.
- Grant:
  - On the winning edge, latch owner, addr, wr (fetch forces 0) and wdata; update last-owner.
  - Owner's gnt is high in the following cycle: the first ACCESS cycle, or the DONE cycle for an error.
- ACCESS outputs:
  - mem_enable=1 and mem_addr/mem_data_in = latched values for all MEM_LAT cycles.
  - mem_wr=1 only in the final ACCESS cycle of a write, giving exactly one write per request.
- Read data: on the final ACCESS edge, capture mem_data_out into the owner's rdata register. Writes load 0.
- DONE: owner's done=1; err=1 only for unaligned addresses, with rdata=0 and no memory activity at all.
- Per-access occupancy: 1 (IDLE) + MEM_LAT + 1 (DONE) cycles. Aligned-request latency from req to done = MEM_LAT+1 cycles.
- rdata holds until that owner's next done. gnt, done and err are 0 outside their pulse.
- Requester protocol: req stays high until done. A requester may re-raise req in DONE for back-to-back accesses. Address and data may change after gnt.
- Reset (rst=0 at an edge):
  - State returns to IDLE, counter to 0, last-owner to data.
  - All outputs, rdata and err are 0.
  - While rst=0, mem_enable and mem_wr are forced 0 combinationally, so an in-flight write is dropped.
  - A requester whose access was aborted receives no done.
- Both requesters unaligned at once: arbitration proceeds normally; each gets its own err in turn.

Test Plan:
- MEM_LAT=2. Fetch i_addr=0x0010, memory word there = 0xBEEF -> i_gnt 1 cycle after req, mem_enable high 2 cycles, i_done 3 cycles after req, i_rdata=0xBEEF, i_err=0, mem_wr never 1.
- Data write d_addr=0x0020, d_wdata=0x1234, then read of 0x0020 -> mem_wr high exactly one cycle (second ACCESS cycle); d_rdata=0x1234 on the read's d_done; write's d_rdata=0.
- i_req and d_req both held high continuously from reset for 4 accesses -> grant order fetch, data, fetch, data; each access occupies 4 cycles.
- d_addr=0x0031 read -> d_gnt and d_done in the same cycle, d_err=1, d_rdata=0, mem_enable never asserted.
- Write to 0x0040 with rst driven low during the final ACCESS cycle -> mem_wr=0 that cycle, memory at 0x0040 unchanged, no d_done, all outputs 0 next cycle; next fetch then wins a tie.
- MEM_LAT=1, single fetch -> mem_enable exactly 1 cycle, i_done 2 cycles after req.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Lets two requesters share one single-port, byte-addressable, 16-bit memory.
// One is an instruction fetch port (read only) and the other is a data port
// (read/write). Each access holds the memory port for MEM_LAT cycles.
// Round-robin arbitration picks between the two. Accesses to odd addresses
// are rejected with an error and never reach the memory.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   i_req, i_addr             fetch request / byte address
//   i_gnt, i_done             fetch accepted / fetch complete pulses
//   i_rdata, i_err            fetched word, unaligned-fetch flag (with i_done)
//   d_req, d_wr, d_addr,      data request, write select, byte address,
//   d_wdata                   write data
//   d_gnt, d_done             data accepted / data complete pulses
//   d_rdata, d_err            read word (0 for writes), unaligned flag
//   mem_enable, mem_wr,       memory pins driven by the arbiter
//   mem_addr, mem_data_in
//   mem_data_out              memory read data (combinational)
//
// state  | meaning
// -------+-------------------------------------------------------
// IDLE   | evaluate requests, latch the winner
// ACCESS | hold memory port for MEM_LAT cycles (down-counter)
// DONE   | one cycle, done (and err) pulse to the owner

module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_done,
    output logic [15:0]           i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_done,
    output logic [15:0]           d_rdata,
    output logic                  d_err,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic       OWN_I  = 1'b0;
    localparam logic       OWN_D  = 1'b1;
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  own_q, own_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  i_gnt_q, i_gnt_d;
    logic                  d_gnt_q, d_gnt_d;
    logic [15:0]           i_rdata_q, i_rdata_d;
    logic [15:0]           d_rdata_q, d_rdata_d;

    logic                  win_d;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [15:0]           cap_data;

    // Data wins when it is the only requester, or on a tie when fetch owned
    // the port last.
    assign win_d    = d_req && (!i_req || (last_q == OWN_I));
    assign sel_addr = win_d ? d_addr : i_addr;
    assign cap_data = wr_q ? 16'h0000 : mem_data_out;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        own_d     = own_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        i_gnt_d   = 1'b0;
        d_gnt_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    own_d   = win_d;
                    last_d  = win_d;
                    addr_d  = sel_addr;
                    wr_d    = win_d && d_wr;
                    wdata_d = win_d ? d_wdata : 16'h0000;
                    err_d   = sel_addr[0];
                    i_gnt_d = !win_d;
                    d_gnt_d = win_d;
                    if (sel_addr[0]) begin
                        // Unaligned: skip the memory, report err with rdata=0.
                        state_d = S_DONE;
                        if (win_d == OWN_D) begin
                            d_rdata_d = 16'h0000;
                        end else begin
                            i_rdata_d = 16'h0000;
                        end
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (own_q == OWN_D) begin
                        d_rdata_d = cap_data;
                    end else begin
                        i_rdata_d = cap_data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            own_q     <= OWN_I;
            last_q    <= OWN_D;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= 16'h0000;
            err_q     <= 1'b0;
            i_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
            i_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            own_q     <= own_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            i_gnt_q   <= i_gnt_d;
            d_gnt_q   <= d_gnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_gnt   = i_gnt_q;
    assign d_gnt   = d_gnt_q;
    assign i_done  = (state_q == S_DONE) && (own_q == OWN_I);
    assign d_done  = (state_q == S_DONE) && (own_q == OWN_D);
    assign i_err   = i_done && err_q;
    assign d_err   = d_done && err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    // rst gates the strobes combinationally so an in-flight write is dropped
    // in the cycle reset is applied.
    assign mem_enable  = rst && (state_q == S_ACCESS);
    assign mem_wr      = mem_enable && wr_q && (cnt_q == 4'd0);
    assign mem_addr    = (state_q == S_ACCESS) ? addr_q : '0;
    assign mem_data_in = (state_q == S_ACCESS) ? wdata_q : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam logic [7:0] IG = 8'h80;
    localparam logic [7:0] ID = 8'h40;
    localparam logic [7:0] IE = 8'h20;
    localparam logic [7:0] DG = 8'h10;
    localparam logic [7:0] DD = 8'h08;
    localparam logic [7:0] DE = 8'h04;
    localparam logic [7:0] ME = 8'h02;
    localparam logic [7:0] MW = 8'h01;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [15:0] daddr;
        logic [15:0] dwdata;
        logic [7:0]  ctl;
        logic [15:0] irdata;
        logic [15:0] drdata;
        logic [15:0] maddr;
        logic [15:0] mdin;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_done, i_err, d_gnt, d_done, d_err;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;

    logic        i_req1, d_req1, d_wr1;
    logic [15:0] i_addr1, d_addr1, d_wdata1;
    logic        i_gnt1, i_done1, i_err1, d_gnt1, d_done1, d_err1;
    logic [15:0] i_rdata1, d_rdata1;
    logic        mem1_enable, mem1_wr;
    logic [15:0] mem1_addr, mem1_data_in, mem1_data_out;

    logic [15:0] mem [0:127];
    logic        preload;
    int          en1_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    vec_t        vq[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(16), .MEM_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    mem_arbiter #(.ADDR_WIDTH(16), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_done(i_done1),
        .i_rdata(i_rdata1), .i_err(i_err1),
        .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_gnt(d_gnt1), .d_done(d_done1), .d_rdata(d_rdata1), .d_err(d_err1),
        .mem_enable(mem1_enable), .mem_wr(mem1_wr), .mem_addr(mem1_addr),
        .mem_data_in(mem1_data_in), .mem_data_out(mem1_data_out)
    );

    // Memory model for the MEM_LAT=2 instance: combinational read, write on edge.
    assign mem_data_out = mem[mem_addr[7:1]];

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 128; k++) mem[k] <= 16'h0000;
            mem[8]  <= 16'hBEEF;   // 0x0010
            mem[16] <= 16'h7777;   // 0x0020
            mem[32] <= 16'h5A5A;   // 0x0040
        end else if (mem_enable && mem_wr) begin
            mem[mem_addr[7:1]] <= mem_data_in;
        end
    end

    assign mem1_data_out = (mem1_addr == 16'h0010) ? 16'hCAFE : 16'h0000;

    always @(posedge clk) begin
        if (mem1_enable) en1_cnt <= en1_cnt + 1;
    end

    function automatic vec_t mk(input logic r, input logic ir, input logic [15:0] ia,
                                input logic dr, input logic dw, input logic [15:0] da,
                                input logic [15:0] dwd, input logic [7:0] c,
                                input logic [15:0] ird, input logic [15:0] drd,
                                input logic [15:0] ma, input logic [15:0] md);
        vec_t v;
        v.rst = r;  v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwr = dw;
        v.daddr = da; v.dwdata = dwd; v.ctl = c; v.irdata = ird; v.drdata = drd;
        v.maddr = ma; v.mdin = md;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst     = v.rst;
        i_req   = v.ireq;
        i_addr  = v.iaddr;
        d_req   = v.dreq;
        d_wr    = v.dwr;
        d_addr  = v.daddr;
        d_wdata = v.dwdata;
    endtask

    task automatic check_row(input int idx, input vec_t v);
        logic [7:0] ctl;
        ctl = {i_gnt, i_done, i_err, d_gnt, d_done, d_err, mem_enable, mem_wr};
        check($sformatf("row%0d ctl{ig,id,ie,dg,dd,de,me,mw}", idx), {24'd0, ctl}, {24'd0, v.ctl});
        check($sformatf("row%0d i_rdata", idx), {16'd0, i_rdata}, {16'd0, v.irdata});
        check($sformatf("row%0d d_rdata", idx), {16'd0, d_rdata}, {16'd0, v.drdata});
        if (v.ctl[1]) check($sformatf("row%0d mem_addr", idx), {16'd0, mem_addr}, {16'd0, v.maddr});
        if (v.ctl[0]) check($sformatf("row%0d mem_data_in", idx), {16'd0, mem_data_in}, {16'd0, v.mdin});
    endtask

    initial begin
        // contention from reset: fetch, data, fetch, data, 4 cycles each
        for (int n = 0; n < 2; n++) begin
            vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, (n==0) ? 8'h00 : 8'h00,
                            (n==0) ? 16'h0 : 16'hBEEF, (n==0) ? 16'h0 : 16'h7777, 0,0));
            vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, IG|ME, (n==0) ? 16'h0 : 16'hBEEF,
                            (n==0) ? 16'h0 : 16'h7777, 16'h10,0));
            vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, ME, (n==0) ? 16'h0 : 16'hBEEF,
                            (n==0) ? 16'h0 : 16'h7777, 16'h10,0));
            vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, ID, 16'hBEEF,
                            (n==0) ? 16'h0 : 16'h7777, 0,0));
            vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, 8'h00, 16'hBEEF,
                            (n==0) ? 16'h0 : 16'h7777, 0,0));
            vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, DG|ME, 16'hBEEF,
                            (n==0) ? 16'h0 : 16'h7777, 16'h20,0));
            vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, ME, 16'hBEEF,
                            (n==0) ? 16'h0 : 16'h7777, 16'h20,0));
            vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, DD, 16'hBEEF, 16'h7777, 0,0));
        end
        vq.push_back(mk(1,0,0,0,0,0,0, 8'h00, 16'hBEEF,16'h7777, 0,0));
        // data write 0x0020 <= 0x1234, single requester (was last owner) wins
        vq.push_back(mk(1,0,0,1,1,16'h20,16'h1234, 8'h00, 16'hBEEF,16'h7777, 0,0));
        vq.push_back(mk(1,0,0,1,1,16'h20,16'h1234, DG|ME, 16'hBEEF,16'h7777, 16'h20,0));
        vq.push_back(mk(1,0,0,1,1,16'h20,16'h1234, ME|MW, 16'hBEEF,16'h7777, 16'h20,16'h1234));
        vq.push_back(mk(1,0,0,1,1,16'h20,16'h1234, DD, 16'hBEEF,16'h0000, 0,0));
        // read back
        vq.push_back(mk(1,0,0,1,0,16'h20,0, 8'h00, 16'hBEEF,16'h0000, 0,0));
        vq.push_back(mk(1,0,0,1,0,16'h20,0, DG|ME, 16'hBEEF,16'h0000, 16'h20,0));
        vq.push_back(mk(1,0,0,1,0,16'h20,0, ME, 16'hBEEF,16'h0000, 16'h20,0));
        vq.push_back(mk(1,0,0,1,0,16'h20,0, DD, 16'hBEEF,16'h1234, 0,0));
        // unaligned data read: gnt+done+err together, no memory activity
        vq.push_back(mk(1,0,0,1,0,16'h31,0, 8'h00, 16'hBEEF,16'h1234, 0,0));
        vq.push_back(mk(1,0,0,1,0,16'h31,0, DG|DD|DE, 16'hBEEF,16'h0000, 0,0));
        // both unaligned: fetch first (data was last), then data
        vq.push_back(mk(1,1,16'h11,1,0,16'h33,0, 8'h00, 16'hBEEF,16'h0000, 0,0));
        vq.push_back(mk(1,1,16'h11,1,0,16'h33,0, IG|ID|IE, 16'h0000,16'h0000, 0,0));
        vq.push_back(mk(1,0,0,1,0,16'h33,0, 8'h00, 16'h0000,16'h0000, 0,0));
        vq.push_back(mk(1,0,0,1,0,16'h33,0, DG|DD|DE, 16'h0000,16'h0000, 0,0));
        // read so d_rdata is nonzero before the reset abort
        vq.push_back(mk(1,0,0,1,0,16'h20,0, 8'h00, 0,0, 0,0));
        vq.push_back(mk(1,0,0,1,0,16'h20,0, DG|ME, 0,0, 16'h20,0));
        vq.push_back(mk(1,0,0,1,0,16'h20,0, ME, 0,0, 16'h20,0));
        vq.push_back(mk(1,0,0,1,0,16'h20,0, DD, 0,16'h1234, 0,0));
        // write to 0x0040 aborted by reset in its final ACCESS cycle
        vq.push_back(mk(1,0,0,1,1,16'h40,16'hFFFF, 8'h00, 0,16'h1234, 0,0));
        vq.push_back(mk(1,0,0,1,1,16'h40,16'hFFFF, DG|ME, 0,16'h1234, 16'h40,0));
        vq.push_back(mk(0,0,0,1,1,16'h40,16'hFFFF, 8'h00, 0,16'h1234, 0,0));
        vq.push_back(mk(1,0,0,0,0,0,0, 8'h00, 0,0, 0,0));
        // first tie after reset goes to fetch
        vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, 8'h00, 0,0, 0,0));
        vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, IG|ME, 0,0, 16'h10,0));
        vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, ME, 0,0, 16'h10,0));
        vq.push_back(mk(1,1,16'h10,1,0,16'h20,0, ID, 16'hBEEF,0, 0,0));
        vq.push_back(mk(1,0,0,0,0,0,0, 8'h00, 16'hBEEF,0, 0,0));

        preload = 1'b1;
        rst = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        i_req1 = 0; i_addr1 = 0; d_req1 = 0; d_wr1 = 0; d_addr1 = 0; d_wdata1 = 0;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check("reset ctl", {24'd0, i_gnt, i_done, i_err, d_gnt, d_done, d_err, mem_enable, mem_wr}, 32'd0);
        check("reset rdata", {i_rdata, d_rdata}, 32'd0);

        for (int r = 0; r < vq.size(); r++) begin
            @(posedge clk);
            #1 apply(vq[r]);
            @(negedge clk);
            check_row(r, vq[r]);
        end

        check("mem 0x0040 after aborted write", {16'd0, mem[32]}, 32'h5A5A);
        check("mem 0x0020 after write", {16'd0, mem[16]}, 32'h1234);

        // MEM_LAT=1 instance: single fetch
        @(posedge clk);
        #1 i_req1 = 1'b1; i_addr1 = 16'h0010;
        @(negedge clk);
        check("lat1 idle {gnt,en,done}", {29'd0, i_gnt1, mem1_enable, i_done1}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat1 access {gnt,en,done}", {29'd0, i_gnt1, mem1_enable, i_done1}, 32'b110);
        check("lat1 mem_addr", {16'd0, mem1_addr}, 32'h0010);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat1 done {gnt,en,done,err}", {28'd0, i_gnt1, mem1_enable, i_done1, i_err1}, 32'b0010);
        check("lat1 i_rdata", {16'd0, i_rdata1}, 32'hCAFE);
        @(posedge clk);
        #1 i_req1 = 1'b0;
        @(negedge clk);
        check("lat1 after done {en,done}", {30'd0, mem1_enable, i_done1}, 32'd0);
        check("lat1 enable cycle count", en1_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
